// File: rtl/gb_seq_pkg.sv
// Shared types for the ghostbus sequencing master: op encoding and FSM state.
package gb_seq_pkg;

    localparam int unsigned OP_W  = 2;
    localparam int unsigned ERR_W = 16;

    typedef enum logic [OP_W-1:0] {
        OP_WRITE = 2'd0,
        OP_READ  = 2'd1,
        OP_CHECK = 2'd2,
        OP_RSVD  = 2'd3
    } gb_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD_STB,
        ST_RD_WAIT,
        ST_RSP
    } gb_state_e;

    // Reserved op code behaves as a plain read.
    function automatic gb_op_e norm_op(input logic [OP_W-1:0] op);
        case (op)
            2'd0:    return OP_WRITE;
            2'd2:    return OP_CHECK;
            default: return OP_READ;
        endcase
    endfunction

endpackage

// File: rtl/gb_seq_delay.sv
// Read-strobe delay line: cap_en rises DEPTH cycles after the strobe cycle.
module gb_seq_delay #(
    parameter int unsigned DEPTH = 3
) (
    input  logic gb_clk,
    input  logic gb_rst,
    input  logic stb,
    output logic cap_en
);

    logic [DEPTH-1:0] sr;

    // Shift the strobe through DEPTH stages; reset drops any strobe in flight.
    always_ff @(posedge gb_clk) begin
        if (gb_rst) begin
            sr <= '0;
        end else begin
            sr[0] <= stb;
            for (int i = 1; i < int'(DEPTH); i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign cap_en = sr[DEPTH-1];

endmodule

// File: rtl/gb_seq_master.sv
// Ghostbus sequencing master: runs WRITE/READ/CHECK bursts from a command
// port and returns one response per read beat (one per whole write burst).
module gb_seq_master
    import gb_seq_pkg::*;
#(
    parameter int unsigned AW       = 24,
    parameter int unsigned DW       = 32,
    parameter int unsigned RD_DELAY = 3,
    parameter int unsigned LENW     = 8
) (
    input  logic              gb_clk,
    input  logic              gb_rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [AW-1:0]     cmd_addr,
    input  logic [DW-1:0]     cmd_data,
    input  logic [DW-1:0]     cmd_mask,
    input  logic [LENW-1:0]   cmd_len,
    output logic [AW-1:0]     gb_addr,
    output logic [DW-1:0]     gb_wdata,
    output logic              gb_wen,
    output logic              gb_rstb,
    input  logic [DW-1:0]     gb_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [OP_W-1:0]   rsp_op,
    output logic [AW-1:0]     rsp_addr,
    output logic [DW-1:0]     rsp_data,
    output logic              rsp_err,
    output logic [ERR_W-1:0]  err_count,
    input  logic              err_clear,
    output logic              busy
);

    gb_state_e        state;
    gb_op_e           op_q;
    logic [DW-1:0]    data_q;
    logic [DW-1:0]    mask_q;
    logic [LENW-1:0]  len_q;
    logic [LENW-1:0]  beat_q;
    logic             cap_en;
    logic             last_beat;
    logic             rsp_fire;

    assign last_beat = (beat_q == len_q);
    assign rsp_fire  = (state == ST_RSP) && rsp_ready;

    gb_seq_delay #(
        .DEPTH (RD_DELAY)
    ) u_delay (
        .gb_clk (gb_clk),
        .gb_rst (gb_rst),
        .stb    (gb_rstb),
        .cap_en (cap_en)
    );

    // Burst sequencer with all bus and response outputs registered.
    always_ff @(posedge gb_clk) begin
        if (gb_rst) begin
            state     <= ST_IDLE;
            op_q      <= OP_WRITE;
            data_q    <= '0;
            mask_q    <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            gb_addr   <= '0;
            gb_wdata  <= '0;
            gb_wen    <= 1'b0;
            gb_rstb   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_op    <= '0;
            rsp_addr  <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        op_q      <= norm_op(cmd_op);
                        data_q    <= cmd_data;
                        mask_q    <= cmd_mask;
                        len_q     <= cmd_len;
                        beat_q    <= '0;
                        gb_addr   <= cmd_addr;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (norm_op(cmd_op) == OP_WRITE) begin
                            state    <= ST_WR;
                            gb_wen   <= 1'b1;
                            gb_wdata <= cmd_data;
                        end else begin
                            state   <= ST_RD_STB;
                            gb_rstb <= 1'b1;
                        end
                    end
                end
                ST_WR: begin
                    if (last_beat) begin
                        gb_wen    <= 1'b0;
                        state     <= ST_RSP;
                        rsp_valid <= 1'b1;
                        rsp_op    <= OP_WRITE;
                        rsp_addr  <= gb_addr;
                        rsp_data  <= gb_wdata;
                        rsp_err   <= 1'b0;
                    end else begin
                        beat_q  <= beat_q + LENW'(1);
                        gb_addr <= gb_addr + AW'(1);
                    end
                end
                ST_RD_STB: begin
                    gb_rstb <= 1'b0;
                    state   <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    if (cap_en) begin
                        state     <= ST_RSP;
                        rsp_valid <= 1'b1;
                        rsp_op    <= op_q;
                        rsp_addr  <= gb_addr;
                        rsp_data  <= gb_rdata;
                        rsp_err   <= (op_q == OP_CHECK) && (|((gb_rdata ^ data_q) & mask_q));
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if ((op_q != OP_WRITE) && !last_beat) begin
                            beat_q  <= beat_q + LENW'(1);
                            gb_addr <= gb_addr + AW'(1);
                            gb_rstb <= 1'b1;
                            state   <= ST_RD_STB;
                        end else begin
                            state     <= ST_IDLE;
                            cmd_ready <= 1'b1;
                            busy      <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    gb_wen    <= 1'b0;
                    gb_rstb   <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    // Saturating mismatch counter; a clear overrides a same-cycle increment.
    always_ff @(posedge gb_clk) begin
        if (gb_rst || err_clear) begin
            err_count <= '0;
        end else if (rsp_fire && (op_q == OP_CHECK) && rsp_err && (err_count != '1)) begin
            err_count <= err_count + ERR_W'(1);
        end
    end

endmodule

// File: doc/gb_seq_master.md
GB_SEQ_MASTER -- requirements
Module: gb_seq_master

Interface
REQ-001 Parameter AW, default 24: ghostbus address width.
REQ-002 Parameter DW, default 32: ghostbus data width.
REQ-003 Parameter RD_DELAY, default 3: cycles from gb_rstb assertion to valid gb_rdata; legal range 1..15.
REQ-004 Parameter LENW, default 8: burst-length field width.
REQ-005 Port gb_clk  in  1  sole clock; all logic on its rising edge.
REQ-006 Port gb_rst  in  1  reset, synchronous, active-high.
REQ-007 Port cmd_valid/cmd_ready  in/out  1/1  command handshake.
REQ-008 Port cmd_op  in  2  operation: WRITE, READ, CHECK.
REQ-009 Port cmd_addr  in  AW  first beat address.
REQ-010 Port cmd_data  in  DW  write data, or expected value for CHECK.
REQ-011 Port cmd_mask  in  DW  CHECK compare mask; 1 = bit compared.
REQ-012 Port cmd_len  in  LENW  beats minus one.
REQ-013 Port gb_addr/gb_wdata/gb_wen/gb_rstb  out  AW/DW/1/1  ghostbus master outputs.
REQ-014 Port gb_rdata  in  DW  ghostbus read data.
REQ-015 Port rsp_valid/rsp_ready  out/in  1/1  response handshake.
REQ-016 Port rsp_op/rsp_addr/rsp_data/rsp_err  out  2/AW/DW/1  response contents.
REQ-017 Port err_count  out  16  saturating CHECK-mismatch count.
REQ-018 Port err_clear  in  1  zeroes err_count.
REQ-019 Port busy  out  1  high whenever state is not IDLE.

Function
REQ-020 FSM states: IDLE, WR, RD_STB, RD_WAIT, RSP.
REQ-021 cmd_ready is high only in IDLE; a command is accepted on a cycle where cmd_valid and cmd_ready are both high, and all fields are registered on that cycle.
REQ-022 Beat i (0..cmd_len) targets cmd_addr+i, wrapping modulo 2^AW.
REQ-023 WR: gb_wen is high for exactly one cycle per beat with gb_addr/gb_wdata stable; back-to-back beats; on the last beat the FSM enters RSP with one completion response (rsp_op=WRITE, rsp_addr=last address, rsp_err=0).
REQ-024 READ/CHECK: RD_STB drives gb_rstb high for one cycle; RD_WAIT counts RD_DELAY cycles; gb_rdata is sampled exactly RD_DELAY cycles after the gb_rstb cycle; the FSM then enters RSP.
REQ-025 gb_addr is held from the strobe until gb_rdata is sampled.
REQ-026 CHECK: rsp_err = |((rdata ^ cmd_data) & cmd_mask); READ always gives rsp_err=0.
REQ-027 RSP: rsp_valid is high until rsp_ready; next beat (RD_STB) or IDLE the cycle after the handshake; the FSM stalls without bus activity while rsp_ready is low.
REQ-028 rsp_valid with rsp_ready already high completes in one cycle; rsp fields are stable while rsp_valid is high.
REQ-029 err_count increments by 1 per accepted CHECK response with rsp_err=1 and saturates at 16'hFFFF.
REQ-030 err_clear on the same cycle as an increment sets err_count to 0; the clear wins.
REQ-031 gb_wen and gb_rstb are never high on the same cycle; both are low outside WR/RD_STB.
REQ-032 Read-beat latency from command acceptance to rsp_valid is RD_DELAY+2 cycles.

Reset
REQ-033 gb_rst forces IDLE; gb_addr, gb_wdata, gb_wen, gb_rstb, rsp_* outputs, err_count and busy are 0, and cmd_ready is 1 on the cycle after release.
REQ-034 Reset mid-burst abandons the burst; no further strobes or responses are issued for it.

Structure
REQ-035 Package gb_seq_pkg holds the op encoding (WRITE=0, READ=1, CHECK=2; 3 is reserved and treated as READ) and the FSM state type.
REQ-036 Sub-module gb_seq_delay is a RD_DELAY-stage strobe shift register producing the capture enable.

Verification
REQ-037 Bench model: a RAM with RD_DELAY=3 read latency behind the ghostbus.
REQ-038 Scenario WRITE addr=0x20, data=0xD0, len=7, then READ of the same range -> 8 wen pulses at 0x20..0x27, one WRITE response, then 8 READ responses each with data 0xD0.
REQ-039 Scenario CHECK addr=0x01, data=0x01, mask=0x0F against a stored value of 0x31 -> rsp_err=0, err_count=0; with a stored value of 0x35 -> rsp_err=1, err_count=1.
REQ-040 Scenario rsp_ready held low for 10 cycles during a len=3 READ -> no gb_rstb while stalled; all 4 responses arrive in order with correct addresses.
REQ-041 Scenario WRITE addr=0xFFFFFF, len=1 -> beats at 0xFFFFFF then 0x000000.
REQ-042 Scenario gb_rst asserted in RD_WAIT of beat 2 of a len=5 CHECK -> no responses after the reset; cmd_ready=1 after release; err_count=0.
REQ-043 Scenario err_clear on the same cycle as a mismatch response -> err_count=0.
